// File: rtl/lemmings_pkg.sv
// Shared definitions for the lemming walker FSMs.
//   - 3-bit state encoding (ST_WALK_L = 0 ... ST_SPLAT = 6) and the enum built on it
//   - default survivable fall length
//   - min_cnt_w(): smallest fall-counter width that can represent a count above a given limit
package lemmings_pkg;

    localparam logic [2:0] ST_WALK_L = 3'd0;
    localparam logic [2:0] ST_WALK_R = 3'd1;
    localparam logic [2:0] ST_FALL_L = 3'd2;
    localparam logic [2:0] ST_FALL_R = 3'd3;
    localparam logic [2:0] ST_DIG_L  = 3'd4;
    localparam logic [2:0] ST_DIG_R  = 3'd5;
    localparam logic [2:0] ST_SPLAT  = 3'd6;

    typedef enum logic [2:0] {
        WALK_L = ST_WALK_L,
        WALK_R = ST_WALK_R,
        FALL_L = ST_FALL_L,
        FALL_R = ST_FALL_R,
        DIG_L  = ST_DIG_L,
        DIG_R  = ST_DIG_R,
        SPLAT  = ST_SPLAT
    } lem_state_t;

    localparam int DEF_FALL_LIMIT = 20;

    // The counter must reach FALL_LIMIT+1 before saturating, so that a fatal
    // fall is distinguishable from the longest survivable one.
    function automatic int min_cnt_w(input int limit);
        int w;
        w = 1;
        while (((1 << w) - 1) <= limit) w++;
        return w;
    endfunction

endpackage

// File: rtl/lemmings_multi_fsm_if.sv
// Signal bundle between the terrain/collision logic and the lemming FSM array.
//   bump_left, bump_right, ground, dig       : terrain -> FSM, one bit per lemming
//   walk_left, walk_right, aaah, digging, splat : FSM -> sprite logic, one-hot per lemming
// Modports: master = terrain/collision side, slave = lemmings_multi_fsm.
interface lemmings_multi_fsm_if #(
    parameter int NUM_LEM = 1
);
    logic [NUM_LEM-1:0] bump_left;
    logic [NUM_LEM-1:0] bump_right;
    logic [NUM_LEM-1:0] ground;
    logic [NUM_LEM-1:0] dig;
    logic [NUM_LEM-1:0] walk_left;
    logic [NUM_LEM-1:0] walk_right;
    logic [NUM_LEM-1:0] aaah;
    logic [NUM_LEM-1:0] digging;
    logic [NUM_LEM-1:0] splat;

    modport master (
        output bump_left, bump_right, ground, dig,
        input  walk_left, walk_right, aaah, digging, splat
    );

    modport slave (
        input  bump_left, bump_right, ground, dig,
        output walk_left, walk_right, aaah, digging, splat
    );
endinterface

// File: rtl/lemming_fsm.sv
// One lemming channel: Moore FSM with walk / fall / dig / splat states and a
// saturating fall-duration counter.
// Ports:
//   clk, areset                         clock, synchronous active-high reset (-> WALK_L)
//   bump_left, bump_right, ground, dig  terrain inputs for this lemming
//   walk_left, walk_right, aaah,
//   digging, splat                      one-hot state decode
module lemming_fsm
    import lemmings_pkg::*;
#(
    parameter int FALL_LIMIT = DEF_FALL_LIMIT,
    parameter int FALL_CNT_W = 5,
    parameter bit DIG_EN     = 1'b1
) (
    input  logic clk,
    input  logic areset,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic splat
);

    localparam logic [FALL_CNT_W-1:0] LIMIT   = FALL_LIMIT[FALL_CNT_W-1:0];
    localparam logic [FALL_CNT_W-1:0] CNT_ONE = {{(FALL_CNT_W-1){1'b0}}, 1'b1};

    lem_state_t            state, state_next;
    logic [FALL_CNT_W-1:0] fall_cnt, fall_cnt_next;
    logic                  dig_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (areset) begin
            state    <= WALK_L;
            fall_cnt <= '0;
        end else begin
            state    <= state_next;
            fall_cnt <= fall_cnt_next;
        end
    end

    assign dig_req = DIG_EN && dig;

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_next    = state;
        fall_cnt_next = fall_cnt;
        case (state)
            WALK_L: begin
                if (!ground) begin
                    state_next    = FALL_L;
                    fall_cnt_next = CNT_ONE;
                end else if (dig_req) begin
                    state_next = DIG_L;
                end else if (bump_left) begin
                    state_next = WALK_R;
                end
            end
            WALK_R: begin
                if (!ground) begin
                    state_next    = FALL_R;
                    fall_cnt_next = CNT_ONE;
                end else if (dig_req) begin
                    state_next = DIG_R;
                end else if (bump_right) begin
                    state_next = WALK_L;
                end
            end
            FALL_L, FALL_R: begin
                if (!ground) begin
                    // Saturate instead of wrapping: a very long fall must still splat.
                    if (fall_cnt != '1) fall_cnt_next = fall_cnt + 1'b1;
                end else if (fall_cnt > LIMIT) begin
                    state_next = SPLAT;
                end else begin
                    state_next = (state == FALL_L) ? WALK_L : WALK_R;
                end
            end
            DIG_L: begin
                if (!ground) begin
                    state_next    = FALL_L;
                    fall_cnt_next = CNT_ONE;
                end
            end
            DIG_R: begin
                if (!ground) begin
                    state_next    = FALL_R;
                    fall_cnt_next = CNT_ONE;
                end
            end
            SPLAT:   state_next = SPLAT;
            default: state_next = WALK_L;   // unused code 7 recovers to a live state
        endcase
    end

    assign walk_left  = (state == WALK_L);
    assign walk_right = (state == WALK_R);
    assign aaah       = (state == FALL_L) || (state == FALL_R);
    assign digging    = (state == DIG_L)  || (state == DIG_R);
    assign splat      = (state == SPLAT);

endmodule

// File: rtl/lemmings_multi_fsm.sv
// Array of NUM_LEM independent lemming FSMs; bit i of every bus vector is lemming i.
// Ports:
//   clk     single clock
//   areset  synchronous active-high reset, all channels -> WALK_L
//   lem     lemmings_multi_fsm_if.slave: terrain inputs in, one-hot state outputs out
module lemmings_multi_fsm
    import lemmings_pkg::*;
#(
    parameter int NUM_LEM    = 1,
    parameter int FALL_LIMIT = DEF_FALL_LIMIT,
    parameter int FALL_CNT_W = 5,
    parameter bit DIG_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  areset,
    lemmings_multi_fsm_if.slave   lem
);

    if (NUM_LEM < 1) begin : g_bad_num_lem
        $error("lemmings_multi_fsm: NUM_LEM must be at least 1");
    end

    if (FALL_CNT_W < min_cnt_w(FALL_LIMIT)) begin : g_bad_cnt_w
        $error("lemmings_multi_fsm: FALL_CNT_W too small to count past FALL_LIMIT");
    end

    for (genvar i = 0; i < NUM_LEM; i++) begin : g_lem
        lemming_fsm #(
            .FALL_LIMIT (FALL_LIMIT),
            .FALL_CNT_W (FALL_CNT_W),
            .DIG_EN     (DIG_EN)
        ) u_lem (
            .clk        (clk),
            .areset     (areset),
            .bump_left  (lem.bump_left[i]),
            .bump_right (lem.bump_right[i]),
            .ground     (lem.ground[i]),
            .dig        (lem.dig[i]),
            .walk_left  (lem.walk_left[i]),
            .walk_right (lem.walk_right[i]),
            .aaah       (lem.aaah[i]),
            .digging    (lem.digging[i]),
            .splat      (lem.splat[i])
        );
    end

endmodule
